// File: rtl/chord_mixer_pkg.sv
// chord_mixer_pkg: shared widths, voice state and step/sine table generators for chord_mixer
package chord_mixer_pkg;
    localparam int NUM_VOICES  = 3;
    localparam int PHASE_W     = 22;
    localparam int SAMPLE_RATE = 48000;
    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int SINE_AW     = 10;
    localparam real PI         = 3.141592653589793;
    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic signed [15:0] sample_t;
    typedef struct packed {
        logic              active;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  count;
        phase_t            phase;
    } voice_t;
    // Note 49 is A4 (440 Hz); note 0 is a rest and never advances.
    function automatic phase_t step_at(int n);
        return n == 0 ? '0 : phase_t'(longint'(440.0 * $pow(2.0, real'(n - 49) / 12.0)
                                     * $pow(2.0, real'(PHASE_W)) / real'(SAMPLE_RATE)));
    endfunction
    function automatic sample_t sine_at(int k);
        return sample_t'(int'(32767.0 * $sin(2.0 * PI * real'(k) / real'(1 << SINE_AW))));
    endfunction
endpackage

// File: rtl/chord_mixer_if.sv
// chord_mixer_if: sequencer-side load signals and codec-side sample signals of chord_mixer
interface chord_mixer_if;
    import chord_mixer_pkg::*;
    logic              play_enable;
    logic [NOTE_W-1:0] note_to_load;
    logic [DUR_W-1:0]  duration;
    logic              load_new_note;
    logic              beat;
    logic              generate_next_sample;
    logic              note_done;
    sample_t           final_sample;
    logic              sample_ready;
    modport master (
        output play_enable, note_to_load, duration, load_new_note, beat, generate_next_sample,
        input  note_done, final_sample, sample_ready
    );
    modport slave (
        input  play_enable, note_to_load, duration, load_new_note, beat, generate_next_sample,
        output note_done, final_sample, sample_ready
    );
endinterface

// File: rtl/chord_mixer_voice.sv
// chord_voice: one voice's note, beat counter, phase accumulator and registered sine lookup
module chord_voice
    import chord_mixer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  dur,
    input  logic              tick,
    input  logic              advance,
    input  logic              lookup,
    output logic              active,
    output logic              expire,
    output sample_t           sample
);
    phase_t  step_rom [1 << NOTE_W];
    sample_t sine_rom [1 << SINE_AW];
    voice_t  v;
    for (genvar n = 0; n < (1 << NOTE_W); n++) begin : g_step
        assign step_rom[n] = step_at(n);
    end
    for (genvar k = 0; k < (1 << SINE_AW); k++) begin : g_sine
        assign sine_rom[k] = sine_at(k);
    end
    assign active = v.active;
    assign expire = v.active && tick && v.count == DUR_W'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            v      <= '0;
            sample <= '0;
        end else begin
            if (load)
                v <= '{active: 1'b1, note: note, count: dur, phase: '0};
            else if (v.active) begin
                if (tick) begin
                    v.count  <= v.count - DUR_W'(1);
                    v.active <= v.count != DUR_W'(1);
                end
                if (advance)
                    v.phase <= v.phase + step_rom[v.note];
            end
            if (lookup)
                sample <= v.active ? sine_rom[v.phase[PHASE_W-1 -: SINE_AW]] : '0;
        end
    end
endmodule

// File: rtl/chord_mixer.sv
// chord_mixer: three-voice note player; allocates loads to idle voices and mixes one sample per request
module chord_mixer
    import chord_mixer_pkg::*;
(
    input logic          clk,
    input logic          reset,
    chord_mixer_if.slave bus
);
    logic                  load_prev, gen_prev, pending, p1, p2;
    logic                  load_rise, gen_rise, busy, start, tick, accept;
    logic [NUM_VOICES-1:0] active, idle, grant, expire;
    sample_t               smp [NUM_VOICES];
    sample_t               sum;
    assign load_rise = bus.load_new_note & ~load_prev;
    assign gen_rise  = bus.generate_next_sample & ~gen_prev;
    assign busy      = p1 | p2;
    assign start     = (gen_rise | pending) & ~busy;
    assign tick      = bus.beat & bus.play_enable;
    assign idle      = ~active;
    assign accept    = load_rise && bus.note_to_load != '0 && bus.duration != '0 && |idle;
    // Isolating the lowest set idle bit picks the lowest-index free voice.
    assign grant     = accept ? idle & (~idle + NUM_VOICES'(1)) : '0;
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        chord_voice u_voice (
            .clk     (clk),
            .reset   (reset),
            .load    (grant[i]),
            .note    (bus.note_to_load),
            .dur     (bus.duration),
            .tick    (tick),
            .advance (start & bus.play_enable),
            .lookup  (p1),
            .active  (active[i]),
            .expire  (expire[i]),
            .sample  (smp[i])
        );
    end
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            sum = sum + (smp[i] >>> 2);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            load_prev        <= 1'b0;
            gen_prev         <= 1'b0;
            pending          <= 1'b0;
            p1               <= 1'b0;
            p2               <= 1'b0;
            bus.note_done    <= 1'b0;
            bus.sample_ready <= 1'b0;
            bus.final_sample <= '0;
        end else begin
            load_prev        <= bus.load_new_note;
            gen_prev         <= bus.generate_next_sample;
            // Hold at most one request while busy; a held one and a fresh one split when idle.
            pending          <= busy ? pending | gen_rise : pending & gen_rise;
            p1               <= start;
            p2               <= p1;
            bus.note_done    <= |expire;
            bus.sample_ready <= p2;
            if (p2)
                bus.final_sample <= sum;
        end
    end
endmodule

// File: tb/tb_chord_mixer.sv
// tb_chord_mixer: randomized and directed checks of chord_mixer against a voice-list reference model
module tb_chord_mixer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    chord_mixer_if bus();
    chord_mixer dut (.clk(clk), .reset(reset), .bus(bus));

    int compared = 0, mismatched = 0;
    int step_ref [64];
    int sine_ref [1024];
    bit m_act [3];
    int m_note [3], m_cnt [3], m_ph [3];
    bit pe;
    int done_cnt = 0;
    int ready_q [$];

    always @(negedge clk) begin
        if (bus.note_done) done_cnt++;
        if (bus.sample_ready) ready_q.push_back(int'(bus.final_sample));
    end

    function automatic void m_clear();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
        end
    endfunction

    function automatic void m_load(int n, int d);
        if (n == 0 || d == 0) return;
        for (int i = 0; i < 3; i++)
            if (!m_act[i]) begin
                m_act[i] = 1; m_note[i] = n; m_cnt[i] = d; m_ph[i] = 0;
                return;
            end
    endfunction

    function automatic int m_beat();
        int expired = 0;
        if (!pe) return 0;
        for (int i = 0; i < 3; i++)
            if (m_act[i]) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin m_act[i] = 0; expired++; end
            end
        return expired > 0 ? 1 : 0;
    endfunction

    function automatic int m_sample();
        int s = 0;
        for (int i = 0; i < 3; i++)
            if (m_act[i]) begin
                if (pe) m_ph[i] = (m_ph[i] + step_ref[m_note[i]]) % 4194304;
                s += sine_ref[m_ph[i] / 4096] >>> 2;
            end
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe(bit v);
        pe = v;
        bus.play_enable = v;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        m_clear();
        set_pe(1);
        cyc();
    endtask

    task automatic do_load(int n, int d);
        bus.note_to_load = 6'(n);
        bus.duration = 6'(d);
        bus.load_new_note = 1'b1;
        cyc();
        bus.load_new_note = 1'b0;
        cyc();
        m_load(n, d);
    endtask

    task automatic do_beat(output int exp_pulses);
        bus.beat = 1'b1;
        cyc();
        bus.beat = 1'b0;
        cyc(); cyc();
        exp_pulses = m_beat();
    endtask

    task automatic do_sample(output int got, output int lat);
        got = 32'h7fff_ffff;
        lat = -1;
        bus.generate_next_sample = 1'b1;
        cyc();
        bus.generate_next_sample = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (bus.sample_ready) begin
                got = int'(bus.final_sample);
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int got, lat, e;
        apply_reset();
        compared++;
        if (bus.final_sample !== 16'sd0) begin mismatched++; $display("FAIL reset_final_sample got %0d expected 0", bus.final_sample); end
        compared++;
        if (bus.sample_ready !== 1'b0) begin mismatched++; $display("FAIL reset_sample_ready got %b expected 0", bus.sample_ready); end
        compared++;
        if (bus.note_done !== 1'b0) begin mismatched++; $display("FAIL reset_note_done got %b expected 0", bus.note_done); end
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL reset_idle_sample got %0d expected %0d", got, e); end
    endtask

    task automatic test_single();
        int got, lat, e, d0;
        apply_reset();
        do_load(28, 1);
        for (int i = 0; i < 3; i++) begin
            do_sample(got, lat);
            e = m_sample();
            compared++;
            if (got !== e || got == 0) begin mismatched++; $display("FAIL single_sample%0d got %0d expected %0d (nonzero)", i, got, e); end
        end
        d0 = done_cnt;
        repeat (95) cyc();
        do_beat(e);
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL single_note_done got %0d pulses expected 1", done_cnt - d0); end
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL single_after_expiry got %0d expected %0d", got, e); end
    endtask

    task automatic test_rest_dropped();
        int got, lat, e, d0;
        apply_reset();
        d0 = done_cnt;
        do_load(0, 8);
        do_load(28, 0);
        for (int i = 0; i < 9; i++) do_beat(e);
        compared++;
        if (done_cnt !== d0) begin mismatched++; $display("FAIL rest_note_done got %0d pulses expected 0", done_cnt - d0); end
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL rest_sample got %0d expected %0d", got, e); end
    endtask

    task automatic test_stagger();
        int got, lat, e, d0, exp_total;
        apply_reset();
        do_load(25, 20); repeat (200) cyc();
        do_load(30, 12); repeat (200) cyc();
        do_load(34, 6);
        d0 = done_cnt;
        exp_total = 0;
        for (int b = 1; b <= 20; b++) begin
            do_beat(e);
            exp_total += e;
            compared++;
            if (done_cnt - d0 !== exp_total) begin mismatched++; $display("FAIL stagger_beat%0d got %0d pulses expected %0d", b, done_cnt - d0, exp_total); end
            if (b % 4 == 0) begin
                do_sample(got, lat);
                e = m_sample();
                compared++;
                if (got !== e) begin mismatched++; $display("FAIL stagger_sample_beat%0d got %0d expected %0d", b, got, e); end
            end
        end
    endtask

    task automatic test_full_and_held();
        int got, lat, e, d0;
        apply_reset();
        do_load(20, 16); do_load(24, 16); do_load(27, 16); do_load(32, 10);
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL full_sample got %0d expected %0d", got, e); end
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) do_beat(e);
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL full_joint_expiry got %0d pulses expected 1", done_cnt - d0); end
        bus.note_to_load = 6'd50;
        bus.duration = 6'd3;
        bus.load_new_note = 1'b1;
        repeat (5) cyc();
        bus.load_new_note = 1'b0;
        cyc();
        m_load(50, 3);
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL held_load_sample got %0d expected %0d", got, e); end
    endtask

    task automatic test_reset_mid();
        int got, lat, e, d0;
        apply_reset();
        do_load(40, 18); do_load(44, 18); do_load(47, 18);
        do_beat(e);
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL mid_chord_sample got %0d expected %0d", got, e); end
        repeat (800) cyc();
        d0 = done_cnt;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m_clear();
        compared++;
        if (bus.final_sample !== 16'sd0 || bus.sample_ready !== 1'b0 || bus.note_done !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_outputs got %0d/%b/%b expected 0/0/0", bus.final_sample, bus.sample_ready, bus.note_done);
        end
        for (int i = 0; i < 20; i++) do_beat(e);
        compared++;
        if (done_cnt !== d0) begin mismatched++; $display("FAIL mid_reset_note_done got %0d pulses expected 0", done_cnt - d0); end
        do_sample(got, lat);
        e = m_sample();
        compared++;
        if (got !== e) begin mismatched++; $display("FAIL mid_reset_sample got %0d expected %0d", got, e); end
    endtask

    task automatic test_a4_phase();
        int got, lat, e;
        apply_reset();
        do_load(49, 40);
        for (int i = 0; i < 120; i++) begin
            do_sample(got, lat);
            e = m_sample();
            compared++;
            if (got !== e || lat !== 3) begin mismatched++; $display("FAIL a4_req%0d got %0d lat %0d expected %0d lat 3", i, got, lat, e); end
        end
    endtask

    task automatic test_pause();
        int got, lat, e, d0;
        apply_reset();
        do_load(33, 2);
        do_sample(got, lat);
        e = m_sample();
        set_pe(0);
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            do_beat(e);
            do_sample(got, lat);
            e = m_sample();
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL pause_sample%0d got %0d expected %0d", i, got, e); end
        end
        compared++;
        if (done_cnt !== d0) begin mismatched++; $display("FAIL pause_note_done got %0d pulses expected 0", done_cnt - d0); end
        set_pe(1);
        do_beat(e); do_beat(e);
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL resume_note_done got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int got, e;
        apply_reset();
        do_load(45, 5);
        do_load(52, 5);
        ready_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus.generate_next_sample = 1'b1; cyc();
            bus.generate_next_sample = 1'b0; cyc();
        end
        repeat (10) cyc();
        compared++;
        if (ready_q.size() !== 3) begin mismatched++; $display("FAIL b2b_ready_count got %0d expected 3", ready_q.size()); end
        for (int i = 0; i < 3; i++) begin
            e = m_sample();
            got = i < ready_q.size() ? ready_q[i] : 32'h7fff_ffff;
            compared++;
            if (got !== e) begin mismatched++; $display("FAIL b2b_sample%0d got %0d expected %0d", i, got, e); end
        end
    endtask

    task automatic test_random();
        int got, lat, e, d0;
        apply_reset();
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_load($urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 63)), $urandom_range(0, 10));
                3, 4, 5: begin
                    d0 = done_cnt;
                    do_beat(e);
                    compared++;
                    if (done_cnt - d0 !== e) begin mismatched++; $display("FAIL rand_beat%0d got %0d pulses expected %0d", it, done_cnt - d0, e); end
                end
                6, 7, 8: begin
                    do_sample(got, lat);
                    e = m_sample();
                    compared++;
                    if (got !== e || lat !== 3) begin mismatched++; $display("FAIL rand_sample%0d got %0d lat %0d expected %0d lat 3", it, got, lat, e); end
                end
                default: set_pe($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    initial begin
        for (int n = 0; n < 64; n++)
            step_ref[n] = n == 0 ? 0 : int'(440.0 * $pow(2.0, real'(n - 49) / 12.0) * 4194304.0 / 48000.0);
        for (int k = 0; k < 1024; k++)
            sine_ref[k] = int'(32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 1024.0));
        reset = 1'b1;
        bus.play_enable = 1'b0;
        bus.note_to_load = '0;
        bus.duration = '0;
        bus.load_new_note = 1'b0;
        bus.beat = 1'b0;
        bus.generate_next_sample = 1'b0;
        pe = 0;
        m_clear();
        test_reset();
        test_single();
        test_rest_dropped();
        test_stagger();
        test_full_and_held();
        test_reset_mid();
        test_a4_phase();
        test_pause();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
